fpdiv_scoreboard: RTL
=====================

// Module: fpdiv_scoreboard
// PURPOSE
//  Parametrised self-checking scoreboard for the floating-point divider flow.
//  - Buffers expected vectors {N, D, Q, RM} in order; compares each DUT result against the oldest entry.
//  - Keeps saturating pass/fail counts and captures mismatch details.
//  - Generalises the fixed f32 single-vector check to any FLEN, with multiple results in flight.
// PARAMETERS
//  FLEN          32  operand/result width in bits (16, 32 or 64)
//  DEPTH         8   expected-vector FIFO depth; power of 2, >= 2
//  CNT_W         16  width of pass/fail counters
//  HALT_ON_FAIL  0   1: stop accepting vectors after the first mismatch
// PORTS
//  clk          in   1                   rising-edge clock
//  reset        in   1                   reset, synchronous, active-low
//  exp_valid    in   1                   expected vector present
//  exp_ready    out  1                   scoreboard accepts vector
//  exp_n        in   FLEN                dividend
//  exp_d        in   FLEN                divisor
//  exp_q        in   FLEN                expected quotient
//  exp_rm       in   2                   rounding mode of the vector
//  res_valid    in   1                   DUT quotient valid this cycle (single-cycle pulse per result)
//  res_q        in   FLEN                DUT quotient
//  pass_cnt     out  CNT_W               matching results, saturating
//  fail_cnt     out  CNT_W               mismatching results, saturating
//  err_valid    out  1                   one-cycle pulse on mismatch
//  err_n        out  FLEN                captured dividend of last mismatch
//  err_d        out  FLEN                captured divisor of last mismatch
//  err_exp      out  FLEN                captured expected quotient of last mismatch
//  err_got      out  FLEN                captured DUT quotient of last mismatch
//  err_rm       out  2                   captured rounding mode of last mismatch
//  underflow    out  1                   sticky: res_valid arrived with FIFO empty
//  level        out  $clog2(DEPTH)+1     FIFO occupancy
//  halted       out  1                   FSM in HALT
// BEHAVIOUR
//  - Reset (reset==0 at posedge):
//    - FIFO flushed; level = 0; all counters, err_*, underflow and halted = 0; FSM to RUN.
//    - Applies mid-operation; in-flight entries are discarded.
//  - Push: on posedge when exp_valid && exp_ready; exp_ready = !full && state==RUN (combinational).
//    - No push when full, even if a pop occurs the same cycle.
//  - Pop/compare: on posedge when res_valid && level != 0; compare res_q with head exp_q bitwise (all FLEN bits).
//    - Match: pass_cnt += 1.
//    - Mismatch: fail_cnt += 1; err_* loaded; err_valid high for exactly the next cycle.
//    - Counters and err_* update 1 cycle after res_valid (registered).
//    - Counters saturate at 2^CNT_W-1; no wrap.
//  - res_valid with level==0: underflow set (sticky until reset); counters unchanged.
//  - Simultaneous push+pop: both occur and level is unchanged.
//    - With level==0 there is no bypass: the push is stored and the result flags underflow.
//  - FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH; full = level==DEPTH, empty = level==0.
//  - FSM RUN/HALT:
//    - RUN -> HALT on the first mismatch when HALT_ON_FAIL==1.
//    - HALT: exp_ready=0; results still pop and compare (draining in-flight entries); halted=1.
//    - HALT -> RUN only via reset.
// CONFIGURATION
//  - NAN_EQUIV_EN defined:
//    - A result is a match when both exp_q and res_q are NaN (exponent all ones, fraction != 0), regardless of sign or payload.
//    - Field split derives from FLEN: 5/10, 8/23, 11/52.
//  - NAN_EQUIV_EN undefined: strict bitwise equality only.
// TESTING
//  - Push 3F800000/40000000/3F000000; res 3F000000 -> pass_cnt=1, fail_cnt=0, err_valid never high.
//  - Push 40400000/3F800000/40400000; res 40400001 -> fail_cnt=1, err_valid 1 cycle, err_got=40400001, err_exp=40400000.
//  - Push 8 vectors, DEPTH=8 -> exp_ready=0, level=8.
//    - Push 9th with a res_valid same cycle -> 9th not accepted, level=7.
//  - res_valid with empty FIFO -> underflow=1, pass_cnt/fail_cnt unchanged.
//    - Then reset low 1 cycle -> underflow=0, level=0.
//  - HALT_ON_FAIL=1: mismatch on 1st of 3 queued vectors -> halted=1, exp_ready=0.
//    - Remaining 2 results still counted.
//  - NAN_EQUIV_EN: expect 7FC00000, res FFC00001 -> pass; without macro -> fail, err_got=FFC00001.

Source files
------------

// File: rtl/fpdiv_scoreboard.sv
// ---------------------------------------------------------------------------
// fpdiv_scoreboard
//   Self-checking scoreboard for the floating-point divider flow. Expected
//   vectors {N, D, Q, RM} are queued in order. Each DUT result is compared
//   against the oldest queued vector. Saturating pass/fail counters are kept,
//   and the details of the most recent mismatch are captured.
//
//   Optional feature macro: NAN_EQUIV_EN
//     defined   -> any NaN result matches any NaN expectation. Sign and
//                  payload are ignored.
//     undefined -> strict bitwise equality on all FLEN bits.
//
// Parameters
//   FLEN          operand/result width (16, 32 or 64)
//   DEPTH         expected-vector FIFO depth (power of 2, >= 2)
//   CNT_W         pass/fail counter width
//   HALT_ON_FAIL  1: refuse new vectors after the first mismatch
//
// Ports
//   clk, reset                  clock, synchronous active-low reset
//   exp_valid/exp_ready         expected-vector handshake
//   exp_n/exp_d/exp_q/exp_rm    expected vector fields
//   res_valid/res_q             DUT result (one pulse per result)
//   pass_cnt/fail_cnt           saturating match/mismatch counters
//   err_valid                   one-cycle pulse after a mismatch
//   err_n/err_d/err_exp/err_got/err_rm  last mismatch details
//   underflow                   sticky: a result arrived with the FIFO empty
//   level                       FIFO occupancy
//   halted                      FSM is in HALT
// ---------------------------------------------------------------------------
module fpdiv_scoreboard #(
  parameter int FLEN         = 32,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 16,
  parameter int HALT_ON_FAIL = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [FLEN-1:0]          exp_n,
  input  logic [FLEN-1:0]          exp_d,
  input  logic [FLEN-1:0]          exp_q,
  input  logic [1:0]               exp_rm,
  input  logic                     res_valid,
  input  logic [FLEN-1:0]          res_q,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic                     err_valid,
  output logic [FLEN-1:0]          err_n,
  output logic [FLEN-1:0]          err_d,
  output logic [FLEN-1:0]          err_exp,
  output logic [FLEN-1:0]          err_got,
  output logic [1:0]               err_rm,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 3 * FLEN + 2;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  // Entry layout: {n, d, q, rm}
  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             err_valid_q, err_valid_d;
  logic [FLEN-1:0]  err_n_q, err_n_d, err_d_q, err_d_d;
  logic [FLEN-1:0]  err_exp_q, err_exp_d, err_got_q, err_got_d;
  logic [1:0]       err_rm_q, err_rm_d;
  logic             underflow_q, underflow_d;
  state_t           state_q, state_d;

  logic             full, empty, push, pop, match, mismatch;
  logic [EW-1:0]    head;
  logic [FLEN-1:0]  head_n, head_d, head_q;
  logic [1:0]       head_rm;

`ifdef NAN_EQUIV_EN
  localparam int EXP_W  = (FLEN == 16) ? 5 : ((FLEN == 64) ? 11 : 8);
  localparam int FRAC_W = FLEN - 1 - EXP_W;

  function automatic logic is_nan(input logic [FLEN-1:0] x);
    return (&x[FLEN-2 -: EXP_W]) && (|x[FRAC_W-1:0]);
  endfunction
`endif

  always_comb begin
    full      = (level_q == LW'(DEPTH));
    empty     = (level_q == '0);
    exp_ready = !full && (state_q == ST_RUN);
    push      = exp_valid && exp_ready;
    pop       = res_valid && !empty;

    head    = mem_q[rd_ptr_q];
    head_n  = head[3*FLEN+1 -: FLEN];
    head_d  = head[2*FLEN+1 -: FLEN];
    head_q  = head[FLEN+1 -: FLEN];
    head_rm = head[1:0];

`ifdef NAN_EQUIV_EN
    match = (head_q == res_q) || (is_nan(head_q) && is_nan(res_q));
`else
    match = (head_q == res_q);
`endif
    mismatch = pop && !match;

    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Counters hold at all-ones instead of wrapping.
    pass_d = pass_q;
    if (pop && match && (pass_q != '1)) pass_d = pass_q + CNT_W'(1);
    fail_d = fail_q;
    if (mismatch && (fail_q != '1)) fail_d = fail_q + CNT_W'(1);

    err_valid_d = mismatch;
    err_n_d     = err_n_q;
    err_d_d     = err_d_q;
    err_exp_d   = err_exp_q;
    err_got_d   = err_got_q;
    err_rm_d    = err_rm_q;
    if (mismatch) begin
      err_n_d   = head_n;
      err_d_d   = head_d;
      err_exp_d = head_q;
      err_got_d = res_q;
      err_rm_d  = head_rm;
    end

    underflow_d = underflow_q || (res_valid && empty);

    state_d = state_q;
    if (mismatch && (HALT_ON_FAIL != 0)) state_d = ST_HALT;
  end

  // FIFO storage carries no reset; occupancy is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {exp_n, exp_d, exp_q, exp_rm};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      err_valid_q <= 1'b0;
      err_n_q     <= '0;
      err_d_q     <= '0;
      err_exp_q   <= '0;
      err_got_q   <= '0;
      err_rm_q    <= '0;
      underflow_q <= 1'b0;
      state_q     <= ST_RUN;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      err_valid_q <= err_valid_d;
      err_n_q     <= err_n_d;
      err_d_q     <= err_d_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
      err_rm_q    <= err_rm_d;
      underflow_q <= underflow_d;
      state_q     <= state_d;
    end
  end

  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign err_valid = err_valid_q;
  assign err_n     = err_n_q;
  assign err_d     = err_d_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;
  assign err_rm    = err_rm_q;
  assign underflow = underflow_q;
  assign level     = level_q;
  assign halted    = (state_q == ST_HALT);

endmodule
